// File: rtl/load_store_unit_if.sv
// Core-side request/response and data_memory bus of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
// resp_valid is a single-cycle pulse with no backpressure, resp_rdata/resp_err are meaningful only with it.
interface load_store_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer onto a word-wide, big-lane-order memory with a registered read port.
// Sub-word stores are done as read-modify-write; errors complete without touching memory.
module load_store_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output logic [2:0]       dbg_state
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] MRG  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [2:0]    state, state_nxt;
    logic          cap_write;
    logic [2:0]    cap_funct3;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic          cap_err;

    logic       acc;
    logic       req_err;
    logic [1:0] req_off;

    assign acc     = bus.req_valid & bus.req_ready;
    assign req_off = bus.req_addr[1:0];

    // funct3 4/5 are loads only; 5 (LHU) also needs halfword alignment.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'd0:    req_err = 1'b0;
            3'd1:    req_err = req_off[0];
            3'd2:    req_err = (req_off != 2'd0);
            3'd4:    req_err = bus.req_write;
            3'd5:    req_err = bus.req_write | req_off[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (bus.req_write && bus.req_funct3 == 3'd2)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = cap_write ? MRG : RESP;
            MRG:     state_nxt = RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cap_write  <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                cap_write  <= bus.req_write;
                cap_funct3 <= bus.req_funct3;
                cap_addr   <= bus.req_addr;
                cap_wdata  <= bus.req_wdata;
                cap_err    <= req_err;
            end
        end
    end

    // Little-endian view of the word just read; byte k of the word sits at bits [8k+7:8k].
    logic [31:0] lw, lw_shr, load_fmt, lane_mask, lane_ins, merged;
    logic [4:0]  sh_amt;

    assign lw     = bswap(bus.mem_rdata);
    assign sh_amt = {cap_addr[1:0], 3'b000};
    assign lw_shr = lw >> sh_amt;

    always_comb begin
        load_fmt = lw;
        case (cap_funct3)
            3'd0:    load_fmt = {{24{lw_shr[7]}}, lw_shr[7:0]};
            3'd1:    load_fmt = {{16{lw_shr[15]}}, lw_shr[15:0]};
            3'd4:    load_fmt = {24'd0, lw_shr[7:0]};
            3'd5:    load_fmt = {16'd0, lw_shr[15:0]};
            default: load_fmt = lw;
        endcase
    end

    assign lane_mask = (cap_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh_amt;
    assign lane_ins  = {16'd0, cap_wdata[15:0]} << sh_amt;
    assign merged    = (lw & ~lane_mask) | (lane_ins & lane_mask);

    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.resp_valid  = (state == RESP);
        bus.resp_err    = (state == RESP) & cap_err;
        bus.resp_rdata  = ((state == RESP) && !cap_write && !cap_err) ? load_fmt : 32'd0;
        bus.mem_read    = (state == RD);
        bus.mem_write   = (state == MRG) || (state == WR);
        bus.mem_address = {cap_addr[AW-1:2], 2'b00};
        bus.mem_wdata   = 32'd0;
        if (state == MRG)
            bus.mem_wdata = bswap(merged);
        else if (state == WR)
            bus.mem_wdata = bswap(cap_wdata);
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory, lane-ordered data_memory model,
// scoreboard of expected {latency, err, rdata} per request.
module tb_load_store_unit;
    localparam int W = 36;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    load_store_unit_if #(.AW(32), .DW(32)) bus ();

    load_store_unit #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // data_memory model: word storage in lane order, registered read
    logic [31:0] dmem [int unsigned];
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    int          both_high = 0;
    logic [31:0] last_wdata = 0;
    logic [31:0] last_maddr = 0;

    always @(posedge clk) begin
        if (bus.mem_read && bus.mem_write) both_high++;
        if (bus.mem_read) begin
            rd_pulses++;
            last_maddr = bus.mem_address;
            bus.mem_rdata <= dmem.exists(32'(bus.mem_address[31:2])) ? dmem[32'(bus.mem_address[31:2])] : 32'd0;
        end
        if (bus.mem_write) begin
            wr_pulses++;
            last_wdata = bus.mem_wdata;
            last_maddr = bus.mem_address;
            dmem[32'(bus.mem_address[31:2])] = bus.mem_wdata;
        end
    end

    // reference memory, one entry per byte address
    logic [7:0] rb [int unsigned];

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return rb.exists(a) ? rb[a] : 8'd0;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w;
        int unsigned k;
        k = 32'(a[31:2]);
        w = dmem.exists(k) ? dmem[k] : 32'd0;
        w[31 - 8 * int'(a[1:0]) -: 8] = b;
        dmem[k] = w;
        rb[a] = b;
    endtask

    // scoreboard: {latency[35:33], err[32], rdata[31:0]}
    logic [W-1:0] exp_q[$];
    int unsigned  acc_cycle = 0;
    int           resp_cnt = 0;
    logic [31:0]  last_rdata = 0;
    logic         last_err = 0;

    task automatic predict(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [W-1:0] e);
        logic        err;
        int          n;
        logic [31:0] v;
        logic [1:0]  off;
        logic [31:0] ba;
        off = a[1:0];
        if (w) err = (f3 > 3'd2);
        else   err = (f3 == 3'd3) || (f3 > 3'd5);
        n = 1 << f3[1:0];
        if ((n == 2 && off[0]) || (n == 4 && off != 2'd0)) err = 1'b1;
        v = 32'd0;
        if (err) begin
            e = {3'd1, 1'b1, 32'd0};
        end else if (w) begin
            for (int i = 0; i < n; i++) begin
                ba = {a[31:2], 2'(off + 2'(i))};
                rb[ba] = wd[8*i +: 8];
            end
            e = {(f3 == 3'd2) ? 3'd2 : 3'd3, 1'b0, 32'd0};
        end else begin
            for (int i = 0; i < n; i++) begin
                ba = {a[31:2], 2'(off + 2'(i))};
                v[8*i +: 8] = rbyte(ba);
            end
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            e = {3'd2, 1'b0, v};
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && bus.resp_valid) begin
            resp_cnt++;
            last_rdata = bus.resp_rdata;
            last_err   = bus.resp_err;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdata", bus.resp_rdata, e[31:0]);
                check("err", 32'(bus.resp_err), 32'(e[32]));
                check("latency", cycle - acc_cycle + 1, 32'(e[35:33]));
            end
        end
    end

    // driver
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [W-1:0] e;
        int           cnt0;
        bit           done;
        @(negedge clk);
        for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
        predict(w, f3, a, wd, e);
        exp_q.push_back(e);
        cnt0 = resp_cnt;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        acc_cycle     = cycle;
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            #1;
            if (resp_cnt != cnt0) done = 1'b1;
        end
        if (!done) begin
            check("resp_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    int w0, r0;

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.mem_rdata  = 32'd0;
        #13;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_maddr", bus.mem_address, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h83); poke(32'h103, 8'h44);
        poke(32'h108, 8'h88); poke(32'h109, 8'h77); poke(32'h10A, 8'h66); poke(32'h10B, 8'h55);
        poke(32'hFFFF_FFFF, 8'hA5);

        do_req(0, 3'd2, 32'h100, 0); check("lw_100", last_rdata, 32'h4483_2211);
        do_req(0, 3'd0, 32'h102, 0); check("lb_102", last_rdata, 32'hFFFF_FF83);
        do_req(0, 3'd4, 32'h102, 0); check("lbu_102", last_rdata, 32'h0000_0083);
        do_req(0, 3'd1, 32'h102, 0); check("lh_102", last_rdata, 32'h0000_4483);
        do_req(0, 3'd5, 32'h100, 0); check("lhu_100", last_rdata, 32'h0000_2211);

        w0 = wr_pulses;
        do_req(1, 3'd0, 32'h101, 32'hDEAD_BEEF);
        check("sb_pulses", 32'(wr_pulses - w0), 32'd1);
        check("sb_wdata", last_wdata, 32'h11EF_8344);
        do_req(0, 3'd2, 32'h100, 0); check("lw_after_sb", last_rdata, 32'h4483_EF11);

        w0 = wr_pulses;
        do_req(1, 3'd2, 32'h104, 32'hCAFE_F00D);
        check("sw_pulses", 32'(wr_pulses - w0), 32'd1);
        check("sw_wdata", last_wdata, 32'h0DF0_FECA);
        do_req(0, 3'd2, 32'h104, 0); check("lw_after_sw", last_rdata, 32'hCAFE_F00D);

        w0 = wr_pulses; r0 = rd_pulses;
        do_req(0, 3'd2, 32'h102, 0);     check("err_lw", {31'd0, last_err}, 32'd1);
        do_req(1, 3'd1, 32'h101, 32'h5); check("err_sh", {31'd0, last_err}, 32'd1);
        do_req(0, 3'd3, 32'h100, 0);     check("err_f3", {31'd0, last_err}, 32'd1);
        do_req(1, 3'd5, 32'h100, 32'h7); check("err_st5", {31'd0, last_err}, 32'd1);
        do_req(0, 3'd5, 32'h103, 0);     check("err_lhu", last_rdata, 32'd0);
        check("err_no_mem", 32'((wr_pulses - w0) + (rd_pulses - r0)), 32'd0);

        do_req(0, 3'd0, 32'hFFFF_FFFF, 0); check("wrap_lb", last_rdata, 32'hFFFF_FFA5);
        check("wrap_maddr", last_maddr, 32'hFFFF_FFFC);
        do_req(1, 3'd0, 32'hFFFF_FFFF, 32'h3C);
        do_req(0, 3'd4, 32'hFFFF_FFFF, 0); check("wrap_lbu", last_rdata, 32'h0000_003C);
        do_req(0, 3'd2, 32'h0, 0);         check("wrap_word0", last_rdata, 32'h0);

        for (int i = 0; i < 40; i++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h100 + 32'($urandom_range(0, 15)), $urandom);

        // reset while the SW sits in WR: the write must be dropped
        w0 = wr_pulses; r0 = resp_cnt;
        @(negedge clk);
        for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h108;
        bus.req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("abort_in_wr", 32'(dbg_state), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        check("abort_mem_write", 32'(bus.mem_write), 32'd0);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        check("abort_maddr", bus.mem_address, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_no_write", 32'(wr_pulses - w0), 32'd0);
        check("abort_no_resp", 32'(resp_cnt - r0), 32'd0);
        check("abort_ready_after", 32'(bus.req_ready), 32'd1);
        do_req(0, 3'd2, 32'h108, 0); check("abort_mem_kept", last_rdata, 32'h5566_7788);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("rw_exclusive", 32'(both_high), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finished", cycle);
        $fatal(1, "timeout");
    end
endmodule
